// File: rtl/mips_muldiv_pkg.sv
// Shared encodings and helpers for the MULT/DIV sequencer.
// Imported by the step datapath and the sequencer top.
package mips_muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int MD_ITERS = 32;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_ITER,
    MD_FIX,
    MD_DONE
  } md_state_t;

  function automatic logic [31:0] md_neg(
    input logic [31:0] v,
    input logic        en
  );
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One shift-add (multiply) or restoring-subtract (divide) iteration.
// Purely combinational; the sequencer registers the result.
module mips_muldiv_step
  import mips_muldiv_pkg::*;
(
  input  logic        is_div_i,
  input  logic [32:0] upper_i,
  input  logic [31:0] lower_i,
  input  logic [31:0] operand_i,
  output logic [32:0] upper_o,
  output logic [31:0] lower_o
);

  logic [32:0] sum;
  logic [32:0] acc;
  logic [32:0] shl;
  logic [33:0] diff;

  always_comb begin
    sum     = upper_i + {1'b0, operand_i};
    acc     = lower_i[0] ? sum : upper_i;
    shl     = {upper_i[31:0], lower_i[31]};
    // Extra bit keeps the borrow visible for any 33-bit partial remainder.
    diff    = {1'b0, shl} - {2'b00, operand_i};
    upper_o = '0;
    lower_o = '0;
    if (is_div_i) begin
      if (!diff[33]) begin
        upper_o = diff[32:0];
        lower_o = {lower_i[30:0], 1'b1};
      end else begin
        upper_o = shl;
        lower_o = {lower_i[30:0], 1'b0};
      end
    end else begin
      upper_o = {1'b0, acc[32:1]};
      lower_o = {acc[0], lower_i[31:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one bit per cycle,
// 32 iteration cycles, one fix-up cycle, one done cycle.
module mips_muldiv_ctrl
  import mips_muldiv_pkg::*;
#(
  parameter int ITERS = MD_ITERS
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        md__start,
  input  logic [1:0]  md__op,
  input  logic [31:0] md__op1,
  input  logic [31:0] md__op2,
  input  logic        md__hi_we,
  input  logic        md__lo_we,
  input  logic [31:0] md__wdata,
  output logic        md__busy,
  output logic        md__done,
  output logic [31:0] md__hi,
  output logic [31:0] md__lo
);

  md_state_t   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        div_q, div_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic        dz_q, dz_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] opnd_q, opnd_d;
  logic [32:0] up_q, up_d;
  logic [31:0] lw_q, lw_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [32:0] step_up;
  logic [31:0] step_lw;
  logic        sgnd;
  logic        s1, s2;
  logic [31:0] mag1, mag2;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  mips_muldiv_step u_step (
    .is_div_i  (div_q),
    .upper_i   (up_q),
    .lower_i   (lw_q),
    .operand_i (opnd_q),
    .upper_o   (step_up),
    .lower_o   (step_lw)
  );

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      op1_q   <= '0;
      opnd_q  <= '0;
      up_q    <= '0;
      lw_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      op1_q   <= op1_d;
      opnd_q  <= opnd_d;
      up_q    <= up_d;
      lw_q    <= lw_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    op1_d   = op1_q;
    opnd_d  = opnd_q;
    up_d    = up_q;
    lw_d    = lw_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    // Opcode bit 0 set means the unsigned variant.
    sgnd = ~md__op[0];
    s1   = sgnd & md__op1[31];
    s2   = sgnd & md__op2[31];
    mag1 = md_neg(md__op1, s1);
    mag2 = md_neg(md__op2, s2);

    prod = {up_q[31:0], lw_q};
    prod = (sa_q ^ sb_q) ? (~prod + 64'd1) : prod;
    quo  = md_neg(lw_q, sa_q ^ sb_q);
    rem  = md_neg(up_q[31:0], sa_q);

    unique case (state_q)
      MD_IDLE: begin
        if (md__hi_we) hi_d = md__wdata;
        if (md__lo_we) lo_d = md__wdata;
        if (md__start) begin
          state_d = MD_ITER;
          cnt_d   = '0;
          div_d   = md__op[1];
          sa_d    = s1;
          sb_d    = s2;
          dz_d    = (md__op2 == 32'd0);
          op1_d   = md__op1;
          up_d    = '0;
          opnd_d  = md__op[1] ? mag2 : mag1;
          lw_d    = md__op[1] ? mag1 : mag2;
        end
      end
      MD_ITER: begin
        up_d  = step_up;
        lw_d  = step_lw;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(ITERS - 1)) state_d = MD_FIX;
      end
      MD_FIX: begin
        state_d = MD_DONE;
        if (!div_q) begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end else if (dz_q) begin
          hi_d = op1_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
      end
      MD_DONE: begin
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  assign md__busy = (state_q != MD_IDLE);
  assign md__done = (state_q == MD_DONE);
  assign md__hi   = hi_q;
  assign md__lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// Directed and random checks of the MULT/DIV sequencer against
// an arithmetic reference model.
module tb_mips_muldiv_ctrl;

  logic        clk;
  logic        rst_b;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks;
  int          n_err;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mips_muldiv_ctrl dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .md__start (start),
    .md__op    (op),
    .md__op1   (op1),
    .md__op2   (op2),
    .md__hi_we (hi_we),
    .md__lo_we (lo_we),
    .md__wdata (wdata),
    .md__busy  (busy),
    .md__done  (done),
    .md__hi    (hi),
    .md__lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(
    input  logic [1:0]  mop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] rh,
    output logic [31:0] rl
  );
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (mop)
      2'b00: begin t = 64'(sa * sb); rh = t[63:32]; rl = t[31:0]; end
      2'b01: begin t = 64'(ua * ub); rh = t[63:32]; rl = t[31:0]; end
      default: begin
        if (b == 32'd0) begin
          rh = a;
          rl = 32'hFFFF_FFFF;
        end else if (mop == 2'b10) begin
          t  = 64'(sa / sb);
          rl = t[31:0];
          t  = 64'(sa % sb);
          rh = t[31:0];
        end else begin
          t  = 64'(ua / ub);
          rl = t[31:0];
          t  = 64'(ua % ub);
          rh = t[31:0];
        end
      end
    endcase
  endtask

  // Start an op in the current cycle (cycle 0); returns in cycle 35.
  task automatic run_op(
    input logic [1:0]  mop,
    input logic [31:0] a,
    input logic [31:0] b,
    input int          poke_c,
    input int          rst_c,
    input bit          same_wr,
    input logic [31:0] wv
  );
    logic [31:0] rh, rl;
    model(mop, a, b, rh, rl);
    op    = mop;
    op1   = a;
    op2   = b;
    start = 1'b1;
    if (same_wr) begin
      hi_we  = 1'b1;
      wdata  = wv;
      exp_hi = wv;
    end
    tick();
    start = 1'b0;
    hi_we = 1'b0;
    op    = 2'($urandom);
    op1   = $urandom;
    op2   = $urandom;
    for (int c = 1; c <= 34; c++) begin
      check("busy", 32'(busy), 32'd1);
      check("done", 32'(done), 32'(c == 34));
      if (c == 34) begin
        exp_hi = rh;
        exp_lo = rl;
      end
      check("hi", hi, exp_hi);
      check("lo", lo, exp_lo);
      if (c == poke_c) begin
        start = 1'b1;
        op    = 2'($urandom);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h1234;
      end
      if (c == rst_c) rst_b = 1'b0;
      tick();
      start = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      if (c == rst_c) begin
        rst_b  = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        for (int k = 0; k < 40; k++) begin
          check("rst_nodone", 32'(done), 32'd0);
          tick();
        end
        return;
      end
    end
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_b    = 1'b0;
    start    = 1'b0;
    op       = '0;
    op1      = '0;
    op2      = '0;
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    wdata    = '0;
    exp_hi   = '0;
    exp_lo   = '0;
    tick();
    tick();
    rst_b = 1'b1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0, 0, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
    run_op(2'b01, 32'd2, 32'd3, 0, 0, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0);
    run_op(2'b11, 32'd7, 32'd2, 0, 0, 0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
    run_op(2'b11, 32'h64, 32'd0, 0, 0, 0, 0);
    run_op(2'b10, 32'h64, 32'd0, 0, 0, 0, 0);
    run_op(2'b00, 32'd1000, 32'hFFFF_FF9C, 10, 0, 0, 0);

    lo_we = 1'b1;
    wdata = 32'h55;
    tick();
    lo_we  = 1'b0;
    exp_lo = 32'h55;
    check("mtlo_lo", lo, exp_lo);
    check("mtlo_hi", hi, exp_hi);

    run_op(2'b11, 32'd100, 32'd7, 0, 0, 1, 32'hCAFE_F00D);
    run_op(2'b00, 32'h1234_5678, 32'h8765_4321, 0, 20, 0, 0);

    for (int i = 0; i < 24; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      int          sel;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if (sel == 1 && $urandom_range(0, 1) == 1) ra = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) begin
        hi_we = 1'b1;
        wdata = $urandom;
        exp_hi = wdata;
        tick();
        hi_we = 1'b0;
        check("mthi_hi", hi, exp_hi);
      end
      run_op(rop, ra, rb, $urandom_range(0, 40), 0,
             1'($urandom_range(0, 1)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_ctrl.md
Name: mips_muldiv_ctrl

Overview:
Multi-cycle sequencer for MULT/MULTU/DIV/DIVU. It owns the architectural HI/LO registers and iterates one bit per cycle through a 33-bit add/sub step. It sits beside mips_ALU in the execute stage. The decode stage starts operations on it, and md__busy stalls the pipeline until HI/LO are final.

Parameters:
ITERS, 32, number of iteration cycles (one bit per cycle); fixed to the 32-bit operand width.

Ports:
clk  input  1  core clock
rst_b  input  1  reset; synchronous, active-low
md__start  input  1  start request; sampled only in IDLE
md__op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
md__op1  input  32  rs value: multiplicand or dividend
md__op2  input  32  rt value: multiplier or divisor
md__hi_we  input  1  MTHI write enable
md__lo_we  input  1  MTLO write enable
md__wdata  input  32  MTHI/MTLO write data
md__busy  output  1  operation in flight; pipeline stall
md__done  output  1  one-cycle pulse; HI/LO final this cycle
md__hi  output  32  HI register (registered)
md__lo  output  32  LO register (registered)

Behaviour:
- Reset (rst_b=0 at a clock edge):
  - state=IDLE; HI=LO=0; busy=0; done=0; iteration count=0.
  - Applies mid-operation too: the in-flight result is discarded and nothing is written.
- States and transitions:
  - IDLE -> ITER on start.
  - ITER runs exactly 32 cycles, then goes to FIX.
  - FIX takes 1 cycle and writes HI/LO.
  - DONE takes 1 cycle with done=1, then returns to IDLE.
- busy = (state != IDLE).
- Timing, with start high in cycle 0:
  - busy is high in cycles 1..34.
  - done is high in cycle 34 only.
  - The new HI/LO are visible from cycle 34.
  - A back-to-back start is accepted in cycle 35.
- Start handling:
  - On start in IDLE, latch op, the magnitudes |op1| and |op2|, and both operand signs.
  - For unsigned ops the magnitudes are the raw values and the signs are 0.
  - start while busy is ignored; no queueing.
- Multiply: shift-add on a 64-bit {acc,mplier} register.
  - Each cycle, if the low bit is 1, add the multiplicand into the upper 33 bits, then shift right by 1.
  - FIX: if the signs differ, take the 64-bit two's complement. HI=[63:32], LO=[31:0].
- Divide: restoring division.
  - Each cycle, shift {rem,quot} left by 1 and trial-subtract the divisor from rem (33-bit).
  - If the result is non-negative, keep it and set quotient bit 1; otherwise restore.
  - FIX:
    - quotient negated if the signs differ;
    - remainder takes the dividend's sign;
    - LO=quotient, HI=remainder.
- Divide by zero: same latency. Results are forced: LO=32'hFFFFFFFF, HI=op1 (original value).
- Overflow: 0x80000000 / -1 (DIV) gives LO=0x80000000, HI=0; no trap.
- MTHI/MTLO:
  - In IDLE, hi_we/lo_we write wdata at the clock edge.
  - While busy, writes are dropped; decode must stall on busy.
  - start and a write in the same IDLE cycle: the write applies now, and the operation's FIX overwrites it later.
- The op/operand inputs are don't-care except in the start cycle.

Decomposition:
- Shared package (next to mips_defines.vh): MD_MULT/MD_MULTU/MD_DIV/MD_DIVU 2-bit encodings; md_state_t enum {MD_IDLE, MD_ITER, MD_FIX, MD_DONE}; MD_ITERS=32.
- One natural sub-module: mips_muldiv_step. It is a combinational single iteration: 33-bit add or subtract plus shift, selected by a mul/div flag, and returns the next {upper,lower} pair.

Test Plan:
- MULT op1=-3 (FFFFFFFD), op2=5 -> done in cycle 34 only, busy in cycles 1..34; HI=FFFFFFFF, LO=FFFFFFF1.
- MULTU op1=op2=FFFFFFFF -> HI=FFFFFFFE, LO=00000001. Then an immediate restart in cycle 35 (MULTU 2*3) -> HI=0, LO=6.
- DIV -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF. DIVU 7/2 -> LO=3, HI=1. DIV 80000000/FFFFFFFF -> LO=80000000, HI=0.
- DIVU 0x64/0 and DIV 0x64/0 -> LO=FFFFFFFF, HI=00000064, same 34-cycle latency.
- start at cycle 10 of an in-flight op, plus MTHI 0x1234 while busy -> both ignored; the first op's result is written. MTLO 0x55 in IDLE -> LO=55 next cycle.
- MULT started, then rst_b=0 at cycle 20 -> next cycle busy=0, done=0, HI=LO=0, and no done pulse ever follows.
